shared_arith_sequencer: RTL and testbench
=========================================

Name: shared_arith_sequencer

Overview:
- Time-multiplexed controller that owns one W-bit add/subtract/compare path and shares it between two requesters.
- Each request carries operands a, b, c, d; the block sequences ab = a+b, then cd = c-d, then altb = (ab < cd) over successive cycles.
- Results return on a valid/ready response channel tagged with the requester id.
- Sits between operand producers and the consumer of the comparison result; replaces per-requester Adder/Subtractor/Comparator instances.

Parameters:
W, 4, operand and result width in bits.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset_L  input  1  reset, asynchronous, active-low.
req_valid  input  2  bit i high: requester i presents operands.
req_ready  output  2  bit i high: requester i's operands captured at this edge.
req_a  input  2*W  requester i operand a at bits [i*W +: W].
req_b  input  2*W  requester i operand b, same packing.
req_c  input  2*W  requester i operand c, same packing.
req_d  input  2*W  requester i operand d, same packing.
resp_valid  output  1  response available.
resp_ready  input  1  consumer accepts response.
resp_id  output  1  index of the requester this response belongs to.
resp_ab  output  W  (a+b) mod 2^W.
resp_cd  output  W  (c-d) mod 2^W.
resp_altb  output  1  1 iff resp_ab < resp_cd, unsigned.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset_L low, asynchronous, any state):
  - State goes to IDLE; operand, ab, cd and altb registers clear to 0.
  - last_grant is set to 1, so requester 0 wins the first tie.
  - All outputs are 0: req_ready, resp_valid, resp_id, resp_ab, resp_cd, resp_altb, busy.
  - An in-flight request is discarded and produces no response.
- States: IDLE -> ADD -> SUB -> CMP -> RESP -> IDLE. There are no other transitions except reset.
- IDLE:
  - Grant is combinational from req_valid.
  - If only one bit is set, that requester is granted.
  - If both bits are set, grant goes to the requester that is not last_grant (round-robin).
  - req_ready[g] = 1 for the granted requester only. It is 0 for both requesters in every other state and when no request is present.
  - At the edge where req_valid[g] and req_ready[g] are both high: capture that requester's a, b, c, d and its id, set last_grant = g, go to ADD.
- ADD: ab <= a + b, carry discarded. Go to SUB.
- SUB: cd <= c - d, borrow discarded (two's-complement wrap). Go to CMP.
- CMP: altb <= (ab < cd), unsigned. Go to RESP.
- RESP:
  - resp_valid = 1; resp_id, resp_ab, resp_cd and resp_altb are driven from registers.
  - All response outputs stay stable while resp_ready is low. There is no timeout.
  - On the edge with resp_ready = 1, go to IDLE.
- Response outputs read 0 in all states except RESP; resp_valid is 0 outside RESP.
- Latency: capture at edge T; resp_valid is high in the cycle after edge T+3. With resp_ready held high, the minimum issue interval is 5 cycles.
- Requests are never dropped. A requester holding req_valid is served after at most one other request.
- req_valid may be deasserted before grant without error. Operands are sampled only at the capture edge.
- busy = (state != IDLE).

Test Plan:
- Req0 a=1001, b=0100, c=1001, d=0100, resp_ready=1 -> resp_valid 4 cycles after the capture edge; resp_id=0, ab=1101, cd=0101, altb=0.
- Req1 a=1001, b=0100, c=0000, d=0001 -> ab=1101, cd=1111 (borrow wrap), altb=1, resp_id=1.
- Req0 a=1111, b=0001, c=0001, d=0001 -> ab=0000 (carry dropped), cd=0000, altb=0 (equal is not less).
- Both req_valid held high from reset with distinct operands -> grants alternate 0, 1, 0, 1; responses carry ids in the same order; req_ready is never high for both bits.
- resp_ready low for 3 cycles in RESP -> resp_* stable for all 3 cycles, req_ready stays 00 despite a pending req_valid, IDLE is entered only after the accept edge.
- reset_L pulsed low during SUB -> all outputs 0 immediately; no response after release; the next request with both valid is granted to requester 0.

Source files
------------

// File: rtl/shared_arith_sequencer.sv
// shared_arith_sequencer: two requesters share one W-bit add/subtract path.
// Each request runs a+b, then c-d, then the unsigned compare (a+b) < (c-d).
// The result is returned on a valid/ready channel tagged with the requester id.
module shared_arith_sequencer #(
    parameter int W = 4
) (
    input  logic           clock,
    input  logic           reset_L,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    input  logic [2*W-1:0] req_c,
    input  logic [2*W-1:0] req_d,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [W-1:0]   resp_ab,
    output logic [W-1:0]   resp_cd,
    output logic           resp_altb,
    output logic           busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        SUB  = 3'd2,
        CMP  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   c_q, c_d;
    logic [W-1:0]   d_q, d_d;
    logic [W-1:0]   ab_q, ab_d;
    logic [W-1:0]   cd_q, cd_d;
    logic           altb_q, altb_d;
    logic           id_q, id_d;
    logic           last_grant_q, last_grant_d;

    logic           any_req;
    logic           grant;
    logic [W-1:0]   alu_x;
    logic [W-1:0]   alu_y;
    logic           alu_sub;
    logic [W:0]     alu_sum;

    // Round-robin arbitration: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        any_req = |req_valid;
        grant   = req_valid[1];
        if (&req_valid) begin
            grant = ~last_grant_q;
        end
    end

    // Ready is only offered in IDLE, and is held low while reset is asserted.
    assign req_ready = (reset_L && (state_q == IDLE) && any_req)
                     ? (grant ? 2'b10 : 2'b01) : 2'b00;

    // Operand routing into the single shared adder; subtraction is x + ~y + 1.
    always_comb begin
        alu_x   = '0;
        alu_y   = '0;
        alu_sub = 1'b0;
        case (state_q)
            ADD: begin
                alu_x = a_q;
                alu_y = b_q;
            end
            SUB: begin
                alu_x   = c_q;
                alu_y   = d_q;
                alu_sub = 1'b1;
            end
            CMP: begin
                alu_x   = ab_q;
                alu_y   = cd_q;
                alu_sub = 1'b1;
            end
            default: begin
                alu_x   = '0;
                alu_y   = '0;
                alu_sub = 1'b0;
            end
        endcase
    end

    // Top bit of a subtraction is the carry-out, which is low exactly when x < y.
    assign alu_sum = {1'b0, alu_x} + {1'b0, alu_y ^ {W{alu_sub}}} + {{W{1'b0}}, alu_sub};

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        d_d          = d_q;
        ab_d         = ab_q;
        cd_d         = cd_q;
        altb_d       = altb_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    a_d          = grant ? req_a[2*W-1:W] : req_a[W-1:0];
                    b_d          = grant ? req_b[2*W-1:W] : req_b[W-1:0];
                    c_d          = grant ? req_c[2*W-1:W] : req_c[W-1:0];
                    d_d          = grant ? req_d[2*W-1:W] : req_d[W-1:0];
                    id_d         = grant;
                    last_grant_d = grant;
                    state_d      = ADD;
                end
            end
            ADD: begin
                ab_d    = alu_sum[W-1:0];
                state_d = SUB;
            end
            SUB: begin
                cd_d    = alu_sum[W-1:0];
                state_d = CMP;
            end
            CMP: begin
                altb_d  = ~alu_sum[W];
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight request.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            d_q          <= '0;
            ab_q         <= '0;
            cd_q         <= '0;
            altb_q       <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            d_q          <= d_d;
            ab_q         <= ab_d;
            cd_q         <= cd_d;
            altb_q       <= altb_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Response fields read zero everywhere except RESP.
    assign resp_valid = (state_q == RESP);
    assign resp_id    = resp_valid ? id_q   : 1'b0;
    assign resp_ab    = resp_valid ? ab_q   : '0;
    assign resp_cd    = resp_valid ? cd_q   : '0;
    assign resp_altb  = resp_valid ? altb_q : 1'b0;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shared_arith_sequencer.sv
// Directed bench for shared_arith_sequencer with a response scoreboard.
module tb_shared_arith_sequencer;

    logic       clock = 1'b0;
    logic       reset_L;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_a, req_b, req_c, req_d;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_id;
    logic [3:0] resp_ab, resp_cd;
    logic       resp_altb;
    logic       busy;

    typedef struct packed {
        logic       id;
        logic [3:0] ab;
        logic [3:0] cd;
        logic       altb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    shared_arith_sequencer #(.W(4)) dut (
        .clock      (clock),
        .reset_L    (reset_L),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .req_d      (req_d),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_ab    (resp_ab),
        .resp_cd    (resp_cd),
        .resp_altb  (resp_altb),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] c, input logic [3:0] d);
        exp_t e;
        e.id   = id;
        e.ab   = 4'((int'(a) + int'(b)) % 16);
        e.cd   = 4'((int'(c) - int'(d) + 16) % 16);
        e.altb = (int'(e.ab) < int'(e.cd));
        return e;
    endfunction

    function automatic exp_t model_bus(input int id);
        return model(id[0], req_a[id*4 +: 4], req_b[id*4 +: 4], req_c[id*4 +: 4], req_d[id*4 +: 4]);
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic drive_op(input int id, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        req_a[id*4 +: 4] = a;
        req_b[id*4 +: 4] = b;
        req_c[id*4 +: 4] = c;
        req_d[id*4 +: 4] = d;
    endtask

    task automatic wait_ready(input string tag, input int id);
        int n = 0;
        while (req_ready == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 16'(req_ready), 16'(1 << id));
    endtask

    // Called one tick after the capture edge; resp_valid must rise on the 4th tick.
    task automatic wait_resp(input string tag);
        int n = 1;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 16'(n), 16'd4);
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 16'(resp_valid), 16'd1);
            chk({tag, "_id"},    16'(resp_id),    16'(e.id));
            chk({tag, "_ab"},    16'(resp_ab),    16'(e.ab));
            chk({tag, "_cd"},    16'(resp_cd),    16'(e.cd));
            chk({tag, "_altb"},  16'(resp_altb),  16'(e.altb));
            $display("txn %s id=%0d ab=%h cd=%h altb=%0d", tag, resp_id, resp_ab, resp_cd, resp_altb);
        end
    endtask

    // Full single-requester transaction with resp_ready high.
    task automatic serve(input string tag, input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        drive_op(id, a, b, c, d);
        req_valid[id] = 1'b1;
        #1;
        wait_ready({tag, "_grant"}, id);
        sb.push_back(model_bus(id));
        tick();
        req_valid = 2'b00;
        chk({tag, "_busy"}, 16'(busy), 16'd1);
        wait_resp({tag, "_latency"});
        check_resp(tag);
        tick();
        chk({tag, "_idle"}, 16'({resp_valid, busy, resp_ab}), 16'd0);
    endtask

    initial begin
        reset_L    = 1'b0;
        req_valid  = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_c      = '0;
        req_d      = '0;
        resp_ready = 1'b1;
        #1;
        req_valid = 2'b11;
        #1;
        chk("reset_outputs",
            16'({req_ready, resp_valid, resp_id, resp_ab, resp_cd, resp_altb, busy}), 16'd0);
        req_valid = 2'b00;
        tick();
        tick();
        reset_L = 1'b1;
        tick();

        // Basic vectors: plain add/sub, borrow wrap, carry drop with equal operands.
        serve("t1", 0, 4'b1001, 4'b0100, 4'b1001, 4'b0100);
        serve("t2", 1, 4'b1001, 4'b0100, 4'b0000, 4'b0001);
        serve("t3", 0, 4'b1111, 4'b0001, 4'b0001, 4'b0001);

        // Round-robin from reset with both requesters held valid.
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        drive_op(0, 4'h2, 4'h3, 4'h9, 4'h1);
        drive_op(1, 4'h7, 4'h8, 4'h4, 4'h6);
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            int n;
            int g;
            g = i % 2;
            wait_ready("rr_grant", g);
            sb.push_back(model_bus(g));
            tick();
            drive_op(g, 4'(i * 3 + 1), 4'(i + 5), 4'(i * 7), 4'(i + 2));
            chk("rr_noready", 16'(req_ready), 16'd0);
            n = 1;
            while (!resp_valid && n < 20) begin
                tick();
                chk("rr_noready", 16'(req_ready), 16'd0);
                n++;
            end
            chk("rr_latency", 16'(n), 16'd4);
            check_resp("rr");
            tick();
        end
        req_valid = 2'b00;
        tick();

        // Backpressure: response held for 3 cycles while another request waits.
        resp_ready = 1'b0;
        drive_op(1, 4'h3, 4'h4, 4'h2, 4'h7);
        req_valid = 2'b10;
        #1;
        wait_ready("stall_grant", 1);
        sb.push_back(model_bus(1));
        tick();
        req_valid = 2'b00;
        wait_resp("stall_latency");
        drive_op(0, 4'hF, 4'hF, 4'h8, 4'h1);
        req_valid = 2'b01;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_id",    16'(resp_id),    16'(sb[0].id));
            chk("stall_ab",    16'(resp_ab),    16'(sb[0].ab));
            chk("stall_cd",    16'(resp_cd),    16'(sb[0].cd));
            chk("stall_altb",  16'(resp_altb),  16'(sb[0].altb));
            chk("stall_valid", 16'(resp_valid), 16'd1);
            chk("stall_ready", 16'(req_ready),  16'd0);
            chk("stall_busy",  16'(busy),       16'd1);
            if (k < 2) tick();
        end
        check_resp("stall");
        resp_ready = 1'b1;
        tick();
        chk("stall_release", 16'({busy, resp_valid, req_ready}), 16'b001);
        sb.push_back(model_bus(0));
        tick();
        req_valid = 2'b00;
        wait_resp("pend_latency");
        check_resp("pend");
        tick();

        // Reset during SUB: request discarded, last_grant returns to 1.
        drive_op(1, 4'h5, 4'h5, 4'h1, 4'h2);
        req_valid = 2'b10;
        #1;
        wait_ready("rst_grant", 1);
        sb.push_back(model_bus(1));
        tick();
        req_valid = 2'b00;
        tick();
        chk("rst_busy_sub", 16'(busy), 16'd1);
        reset_L = 1'b0;
        #1;
        chk("rst_outputs",
            16'({req_ready, resp_valid, resp_id, resp_ab, resp_cd, resp_altb, busy}), 16'd0);
        sb.delete();
        drive_op(0, 4'h6, 4'h1, 4'hC, 4'h3);
        drive_op(1, 4'hA, 4'hA, 4'h0, 4'h0);
        req_valid = 2'b11;
        #1;
        chk("rst_ready_held", 16'(req_ready), 16'd0);
        tick();
        tick();
        chk("rst_no_resp", 16'({resp_valid, busy}), 16'd0);
        reset_L = 1'b1;
        #1;
        chk("rst_first_grant", 16'(req_ready), 16'b01);
        sb.push_back(model_bus(0));
        tick();
        req_valid = 2'b00;
        wait_resp("rst_latency");
        check_resp("rst_after");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
